// File: rtl/t06_apple_eat_ctrl.sv
// Apple consumer: detects the snake head landing on the apple and pulses good_collision.
// Tracks score and length, and suppresses double-eats while the generator relocates the apple.
module t06_apple_eat_ctrl #(
    parameter int MAX_LENGTH    = 30,
    parameter int INIT_LENGTH   = 3,
    parameter int SCORE_W       = 8,
    parameter int REARM_TIMEOUT = 16
) (
    input  logic                              system_clk,
    input  logic                              nreset,
    input  logic                              game_active,
    input  logic                              move_tick,
    input  logic [3:0]                        snake_head_x,
    input  logic [3:0]                        snake_head_y,
    input  logic [7:0]                        apple_location,
    output logic                              good_collision,
    output logic                              grow,
    output logic [SCORE_W-1:0]                score,
    output logic [$clog2(MAX_LENGTH+1)-1:0]   snake_length,
    output logic                              length_full
);

    localparam int LEN_W = $clog2(MAX_LENGTH + 1);
    localparam int TMR_W = $clog2(REARM_TIMEOUT);

    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LENGTH);
    localparam logic [LEN_W-1:0] INIT_LEN_C = LEN_W'(INIT_LENGTH);
    localparam logic [TMR_W-1:0] TMO_LAST_C = TMR_W'(REARM_TIMEOUT - 1);
    localparam logic [7:0]       APPLE_RST  = 8'h55;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] WAIT_NEW = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               good_collision_q, good_collision_d;
    logic               grow_q, grow_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEN_W-1:0]   snake_length_q, snake_length_d;
    logic [7:0]         snapshot_q, snapshot_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               hit;

    assign hit = move_tick & ({snake_head_y, snake_head_x} == apple_location);

    always_comb begin
        state_d          = state_q;
        good_collision_d = 1'b0;
        grow_d           = 1'b0;
        score_d          = score_q;
        snake_length_d   = snake_length_q;
        snapshot_d       = snapshot_q;
        timer_d          = timer_q;

        // Dropping game_active wins over everything, including a hit in the same cycle.
        if (!game_active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d        = ARMED;
                    score_d        = '0;
                    snake_length_d = INIT_LEN_C;
                end
                ARMED: begin
                    if (hit) begin
                        good_collision_d = 1'b1;
                        snapshot_d       = apple_location;
                        timer_d          = '0;
                        state_d          = WAIT_NEW;
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        if (snake_length_q < MAX_LEN_C) begin
                            snake_length_d = snake_length_q + LEN_W'(1);
                            grow_d         = 1'b1;
                        end
                    end
                end
                WAIT_NEW: begin
                    // The timeout re-arms even if the generator re-picked the same spot.
                    timer_d = timer_q + TMR_W'(1);
                    if ((apple_location != snapshot_q) || (timer_q == TMO_LAST_C)) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state_q          <= IDLE;
            good_collision_q <= 1'b0;
            grow_q           <= 1'b0;
            score_q          <= '0;
            snake_length_q   <= INIT_LEN_C;
            snapshot_q       <= APPLE_RST;
            timer_q          <= '0;
        end else begin
            state_q          <= state_d;
            good_collision_q <= good_collision_d;
            grow_q           <= grow_d;
            score_q          <= score_d;
            snake_length_q   <= snake_length_d;
            snapshot_q       <= snapshot_d;
            timer_q          <= timer_d;
        end
    end

    assign good_collision = good_collision_q;
    assign grow           = grow_q;
    assign score          = score_q;
    assign snake_length   = snake_length_q;
    assign length_full    = (snake_length_q == MAX_LEN_C);

endmodule
